sync_fifo_ctrl: RTL and testbench

//  Parametrised single-clock FIFO for the UART/IrDA byte path. It combines storage,

---
 rtl/sync_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Single-clock byte FIFO with occupancy count, threshold flags, sticky error flags,
// synchronous flush and a one-cycle read-data valid strobe.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_TH      = 14,
    parameter int AE_TH      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wr_data,
    input  logic                  rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_TH[ADDR_WIDTH:0];

    if (AF_TH < 1 || AF_TH > DEPTH) begin : g_bad_af
        $error("sync_fifo_ctrl: AF_TH out of range 1..DEPTH");
    end
    if (AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_ctrl: AE_TH out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  rd_acc, wr_acc, wr_en;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A full FIFO can still take a write when a read frees a slot in the same cycle.
    assign rd_acc = rd_data & ~empty;
    assign wr_acc = wr_data & (~full | rd_acc);
    assign wr_en  = wr_acc & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d    = rd_ptr_q + 1'b1;
                out_data_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - 1'b1;
            end
        end
        // A new error in the clr_err cycle takes precedence over the clear.
        ovf_d = ovf_q & ~clr_err;
        unf_d = unf_q & ~clr_err;
        if (!flush && wr_data && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (!flush && rd_data && empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data;
        end
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: a queue model predicts contents and flags,
// expected read bytes are queued at read request and compared when out_valid appears.
module tb_sync_fifo_ctrl;
    logic       clock = 1'b0;
    logic       reset, flush, clr_err, wr_data, rd_data;
    logic [7:0] data;
    logic [7:0] out_data;
    logic       out_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] sb[$];
    bit         exp_valid = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    logic [7:0] last_dout = 8'h00;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_TH(14), .AE_TH(2)) dut (
        .clock(clock), .reset(reset), .flush(flush), .clr_err(clr_err),
        .data(data), .wr_data(wr_data), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        check_eq({tag, ".valid"}, int'(out_valid), int'(exp_valid));
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq({tag, ".sb_underrun"}, sb.size(), 1);
            end else begin
                last_dout = sb.pop_front();
            end
        end
        check_eq({tag, ".dout"}, int'(out_data), int'(last_dout));
        check_eq({tag, ".count"}, int'(count), n);
        check_eq({tag, ".empty"}, int'(empty), int'(n == 0));
        check_eq({tag, ".full"}, int'(full), int'(n == 16));
        check_eq({tag, ".ae"}, int'(almost_empty), int'(n <= 2));
        check_eq({tag, ".af"}, int'(almost_full), int'(n >= 14));
        check_eq({tag, ".ovf"}, int'(overflow), int'(m_ovf));
        check_eq({tag, ".unf"}, int'(underflow), int'(m_unf));
    endtask

    task automatic step(input string tag, input bit wr, input bit rd, input logic [7:0] d,
                        input bit fl, input bit ce);
        bit m_empty, m_full, racc, wacc, oset, uset;
        wr_data = wr; rd_data = rd; data = d; flush = fl; clr_err = ce;
        m_empty = (mq.size() == 0);
        m_full  = (mq.size() == 16);
        racc = rd && !m_empty;
        wacc = wr && (!m_full || racc);
        oset = !fl && wr && !wacc;
        uset = !fl && rd && m_empty;
        exp_valid = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (racc) begin
                sb.push_back(mq.pop_front());
                exp_valid = 1'b1;
            end
            if (wacc) mq.push_back(d);
        end
        m_ovf = oset ? 1'b1 : (ce ? 1'b0 : m_ovf);
        m_unf = uset ? 1'b1 : (ce ? 1'b0 : m_unf);
        @(posedge clock);
        #1;
        wr_data = 0; rd_data = 0; flush = 0; clr_err = 0;
        check_all(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        exp_valid = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        last_dout = 8'h00;
    endtask

    initial begin
        reset = 1'b1; flush = 0; clr_err = 0; wr_data = 0; rd_data = 0; data = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // fill, overflow
        for (int i = 0; i < 16; i++) step("fill", 1, 0, 8'(i), 0, 0);
        step("over", 1, 0, 8'hAA, 0, 0);
        // drain, underflow
        for (int i = 0; i < 16; i++) step("drain", 0, 1, 8'h00, 0, 0);
        step("under", 0, 1, 8'h00, 0, 0);
        step("clr", 0, 0, 8'h00, 0, 1);
        // pointer wrap
        for (int i = 0; i < 10; i++) step("w10", 1, 0, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 10; i++) step("r10", 0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 12; i++) step("w12", 1, 0, 8'(8'h80 + i), 0, 0);
        for (int i = 0; i < 12; i++) step("r12", 0, 1, 8'h00, 0, 0);
        // simultaneous rd/wr at full and at empty
        for (int i = 0; i < 16; i++) step("fill2", 1, 0, 8'(8'hC0 + i), 0, 0);
        step("rw_full", 1, 1, 8'h5A, 0, 0);
        for (int i = 0; i < 16; i++) step("drain2", 0, 1, 8'h00, 0, 0);
        step("rw_empty", 1, 1, 8'hA5, 0, 0);
        // flush at count 7 with a concurrent write, then clear errors
        for (int i = 0; i < 6; i++) step("to7", 1, 0, 8'(8'h20 + i), 0, 0);
        step("flush", 1, 0, 8'hEE, 1, 0);
        step("clr2", 0, 0, 8'h00, 0, 1);
        step("clr_set", 0, 1, 8'h00, 0, 1);
        step("clr3", 0, 0, 8'h00, 0, 1);
        // random traffic
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
        end
        // asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) step("burst", 1, 0, 8'(8'h60 + i), 0, 0);
        step("burst_rd", 1, 1, 8'h70, 0, 0);
        reset = 1'b1;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b0;
        step("post_rst", 1, 0, 8'h11, 0, 0);
        step("post_rd", 0, 1, 8'h00, 0, 0);
        check_eq("sb_left", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
